result_batcher: RTL

- Return path of the op/A/B stimulus batcher. Collects the 16-bit results the bfm produces on each `done` pulse and packs them into batches of NUM results.
- Hands each batch to the software/DPI side over a valid/ready handshake: RTL-to-host, the opposite direction of the payload feed.
- Double-buffered: collection continues while a completed batch waits to be drained.
- Reports partial-batch flush, a drop/overflow condition and a running result count.

---
 rtl/batch_pkg.sv | 15 +
 rtl/batch_slot_buf.sv | 35 +++
 rtl/result_batcher.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/batch_pkg.sv
// Shared definitions for the stimulus batcher and its return-path result batcher.
// The batch size lives here so both ends of the link agree on it.
package batch_pkg;

  localparam int BATCH_NUM       = 100;
  localparam int BATCH_RES_WIDTH = 16;

  typedef logic [BATCH_RES_WIDTH-1:0] result_t;

  typedef enum logic {
    FILL    = 1'b0,
    BLOCKED = 1'b1
  } batch_state_e;

endpackage

// File: rtl/batch_slot_buf.sv
// NUM-slot register file written one slot at a time by index, cleared in one
// cycle, and read in parallel as a flat vector (slot k at [k*WIDTH +: WIDTH]).
module batch_slot_buf #(
  parameter int NUM       = 4,
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 3
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clr_i,
  input  logic                 wr_en_i,
  input  logic [IDX_WIDTH-1:0] wr_idx_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  output logic [NUM*WIDTH-1:0] rd_data_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_slot
      logic [WIDTH-1:0] r_slot;

      // Clear beats write so a transferred buffer always restarts all-zero.
      always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
          r_slot <= '0;
        end else if (wr_en_i && (wr_idx_i == IDX_WIDTH'(gi))) begin
          r_slot <= wr_data_i;
        end
      end

      assign rd_data_o[gi*WIDTH +: WIDTH] = r_slot;
    end
  endgenerate

endmodule

// File: rtl/result_batcher.sv
// Packs bfm results into NUM-word batches and hands them to the host over
// valid/ready; a fill buffer keeps collecting while the output buffer drains.
module result_batcher
  import batch_pkg::*;
#(
  parameter int NUM       = BATCH_NUM,
  parameter int RES_WIDTH = BATCH_RES_WIDTH,
  parameter int CNT_WIDTH = $clog2(NUM + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     done_i,
  input  logic [RES_WIDTH-1:0]     res_i,
  input  logic                     flush_i,
  output logic                     batch_valid_o,
  input  logic                     batch_ready_i,
  output logic [NUM*RES_WIDTH-1:0] batch_data_o,
  output logic [CNT_WIDTH-1:0]     batch_count_o,
  output logic                     overflow_o,
  output logic [31:0]              total_o
);

  batch_state_e r_state;
  batch_state_e w_state_next;

  logic [CNT_WIDTH-1:0]     r_fill_cnt;
  logic [CNT_WIDTH-1:0]     w_fill_cnt_next;
  logic [CNT_WIDTH-1:0]     w_load_cnt;
  logic [NUM*RES_WIDTH-1:0] w_fill_data;
  logic [NUM*RES_WIDTH-1:0] w_merged;

  logic [NUM*RES_WIDTH-1:0] r_out_data;
  logic [CNT_WIDTH-1:0]     r_out_cnt;
  logic                     r_out_valid;
  logic                     r_overflow;
  logic [31:0]              r_total;

  logic w_hs;
  logic w_out_free;
  logic w_accept;
  logic w_drop;
  logic w_due;
  logic w_transfer;

  assign w_hs       = r_out_valid & batch_ready_i;
  assign w_out_free = ~r_out_valid | w_hs;
  assign w_load_cnt = r_fill_cnt + CNT_WIDTH'(w_accept);

  batch_slot_buf #(
    .NUM       (NUM),
    .WIDTH     (RES_WIDTH),
    .IDX_WIDTH (CNT_WIDTH)
  ) u_fill_buf (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clr_i     (w_transfer),
    .wr_en_i   (w_accept),
    .wr_idx_i  (r_fill_cnt),
    .wr_data_i (res_i),
    .rd_data_o (w_fill_data)
  );

  // The word arriving on a transfer edge is folded into the outgoing batch.
  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_merge
      assign w_merged[gi*RES_WIDTH +: RES_WIDTH] =
        (w_accept && (r_fill_cnt == CNT_WIDTH'(gi))) ? res_i
                                                     : w_fill_data[gi*RES_WIDTH +: RES_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_fill_cnt_next = r_fill_cnt;
    w_accept        = 1'b0;
    w_drop          = 1'b0;
    w_due           = 1'b0;
    w_transfer      = 1'b0;
    case (r_state)
      FILL: begin
        w_accept = done_i;
        w_due    = (done_i && (r_fill_cnt == CNT_WIDTH'(NUM - 1))) ||
                   (flush_i && ((r_fill_cnt != '0) || done_i));
        if (w_due && w_out_free) begin
          w_transfer      = 1'b1;
          w_fill_cnt_next = '0;
        end else begin
          // A due batch that cannot move stays in the fill buffer, which
          // is then frozen until the output side drains.
          w_fill_cnt_next = w_load_cnt;
          if (w_due) begin
            w_state_next = BLOCKED;
          end
        end
      end
      BLOCKED: begin
        w_drop = done_i;
        if (w_hs) begin
          w_transfer      = 1'b1;
          w_fill_cnt_next = '0;
          w_state_next    = FILL;
        end
      end
      default: begin
        w_state_next = FILL;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_fill_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_cnt   <= '0;
      r_overflow  <= 1'b0;
      r_total     <= '0;
    end else begin
      r_fill_cnt <= w_fill_cnt_next;
      if (w_transfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_merged;
        r_out_cnt   <= w_load_cnt;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_accept) begin
        r_total <= r_total + 32'd1;
      end
    end
  end

  assign batch_valid_o = r_out_valid;
  assign batch_data_o  = r_out_data;
  assign batch_count_o = r_out_cnt;
  assign overflow_o    = r_overflow;
  assign total_o       = r_total;

endmodule
